// File: rtl/updown_counter_pkg.sv
// Shared types and constants for the modulo-2^WIDTH up/down counter.
package updown_counter_pkg;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

  // Sized to the widest legal count; the module slices it down to WIDTH.
  localparam logic [31:0] COUNT_RST = '0;

endpackage

// File: rtl/updown_counter.sv
// Synchronous binary up/down counter, modulo 2^WIDTH, no saturation.
// Optional terminal-count output tc is enabled by defining UPDOWN_COUNTER_TC_EN.
module updown_counter
  import updown_counter_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
`ifdef UPDOWN_COUNTER_TC_EN
  output logic             tc,
`endif
  output logic [WIDTH-1:0] q
);

  typedef logic [WIDTH-1:0] count_t;

  localparam count_t ONE   = count_t'(1);
  localparam count_t ZERO  = COUNT_RST[WIDTH-1:0];
  localparam count_t MAX_V = '1;

  // No handshake: enable is a plain level qualifier sampled on every rising
  // edge; enable=0 holds q, and there is no backpressure in either direction.
  dir_e   dir;
  count_t q_next;

  always_comb begin
    dir    = dir_e'(up_down);
    q_next = q;
    if (dir == DIR_UP) begin
      q_next = q + ONE;
    end else begin
      q_next = q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= ZERO;
    end else if (enable) begin
      q <= q_next;
    end
  end

`ifdef UPDOWN_COUNTER_TC_EN
  logic wrap;

  // A wrap is an enabled step across the 0 / 2^WIDTH-1 boundary.
  always_comb begin
    wrap = 1'b0;
    if (enable) begin
      if (dir == DIR_UP) begin
        wrap = (q == MAX_V);
      end else begin
        wrap = (q == ZERO);
      end
    end
  end

  // Reset forcing q to 0 is not a wrap, so tc stays low through it.
  always_ff @(posedge clk) begin
    if (reset) begin
      tc <= 1'b0;
    end else begin
      tc <= wrap;
    end
  end
`endif

endmodule

// File: tb/tb_updown_counter.sv
// Directed self-checking bench for updown_counter (WIDTH=4).
// Define UPDOWN_COUNTER_TC_EN to also check the terminal-count output.
module tb_updown_counter;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         up_down;
  logic [W-1:0] q;
`ifdef UPDOWN_COUNTER_TC_EN
  logic         tc;
`endif

  int total = 0;
  int bad   = 0;

  logic [W-1:0] exp_q[$];

  updown_counter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .up_down(up_down),
`ifdef UPDOWN_COUNTER_TC_EN
    .tc     (tc),
`endif
    .q      (q)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset   = 1'b1;
    enable  = 1'b0;
    up_down = 1'b1;
  end

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled there too, well away from the next edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_value(input int n);
    reset   = 1'b1;
    enable  = 1'b0;
    step();
    reset   = 1'b0;
    enable  = 1'b1;
    up_down = 1'b1;
    repeat (n) step();
    enable  = 1'b0;
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    enable  = 1'b1;
    up_down = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (q !== 4'd0) begin
        bad++;
        $display("FAIL reset_hold cycle %0d: q=%0d expected 0", i, q);
      end
`ifdef UPDOWN_COUNTER_TC_EN
      total++;
      if (tc !== 1'b0) begin
        bad++;
        $display("FAIL reset_tc cycle %0d: tc=%b expected 0", i, tc);
      end
`endif
    end
    reset  = 1'b0;
    enable = 1'b0;
    step();
    total++;
    if (q !== 4'd0) begin
      bad++;
      $display("FAIL reset_release: q=%0d expected 0", q);
    end
  endtask

  task automatic test_count_up_wrap();
    logic [W-1:0] e;
    load_value(0);
    exp_q.delete();
    for (int v = 1; v <= 15; v++) exp_q.push_back(4'(v));
    exp_q.push_back(4'd0);
    exp_q.push_back(4'd1);
    enable  = 1'b1;
    up_down = 1'b1;
    for (int i = 0; i < 17; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (q !== e) begin
        bad++;
        $display("FAIL count_up step %0d: q=%0d expected %0d", i, q, e);
      end
`ifdef UPDOWN_COUNTER_TC_EN
      total++;
      if (tc !== (i == 15)) begin
        bad++;
        $display("FAIL count_up_tc step %0d: tc=%b expected %b", i, tc, (i == 15));
      end
`endif
    end
    enable = 1'b0;
  endtask

  task automatic test_count_down_wrap();
    logic [W-1:0] e;
    load_value(0);
    exp_q.delete();
    exp_q.push_back(4'd15);
    exp_q.push_back(4'd14);
    exp_q.push_back(4'd13);
    enable  = 1'b1;
    up_down = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      e = exp_q.pop_front();
      total++;
      if (q !== e) begin
        bad++;
        $display("FAIL count_down step %0d: q=%0d expected %0d", i, q, e);
      end
`ifdef UPDOWN_COUNTER_TC_EN
      total++;
      if (tc !== (i == 0)) begin
        bad++;
        $display("FAIL count_down_tc step %0d: tc=%b expected %b", i, tc, (i == 0));
      end
`endif
    end
    enable = 1'b0;
  endtask

  task automatic test_hold();
    load_value(5);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      up_down = ~up_down;
      step();
      total++;
      if (q !== 4'd5) begin
        bad++;
        $display("FAIL hold cycle %0d: q=%0d expected 5", i, q);
      end
`ifdef UPDOWN_COUNTER_TC_EN
      total++;
      if (tc !== 1'b0) begin
        bad++;
        $display("FAIL hold_tc cycle %0d: tc=%b expected 0", i, tc);
      end
`endif
    end
  endtask

  task automatic test_direction_change();
    logic [W-1:0] e;
    load_value(7);
    exp_q.delete();
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd9);
    exp_q.push_back(4'd8);
    exp_q.push_back(4'd7);
    exp_q.push_back(4'd6);
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      up_down = (i < 2);
      step();
      e = exp_q.pop_front();
      total++;
      if (q !== e) begin
        bad++;
        $display("FAIL dir_change step %0d: q=%0d expected %0d", i, q, e);
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_reset_mid();
    load_value(10);
    enable  = 1'b1;
    up_down = 1'b1;
    reset   = 1'b1;
    step();
    total++;
    if (q !== 4'd0) begin
      bad++;
      $display("FAIL reset_mid: q=%0d expected 0", q);
    end
`ifdef UPDOWN_COUNTER_TC_EN
    total++;
    if (tc !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid_tc: tc=%b expected 0", tc);
    end
`endif
    reset = 1'b0;
    step();
    total++;
    if (q !== 4'd1) begin
      bad++;
      $display("FAIL reset_resume: q=%0d expected 1", q);
    end
    enable = 1'b0;
  endtask

  // Sequencer and final report
  initial begin
    #1;
    test_reset();
    test_count_up_wrap();
    test_count_down_wrap();
    test_hold();
    test_direction_change();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
